mlp_host_sequencer: RTL

// - Byte-stream command front end that sits directly upstream of the MLP top level.
// - Decodes host commands and drives the MLP weight-FIFO pushes, initial activation writes,

---
 rtl/mlp_host_sequencer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mlp_host_sequencer.sv
// Host byte-command front end for the MLP: weight/activation loading, run, result return.
// Optional WAIT_DONE watchdog is enabled with `define MLP_HOST_TIMEOUT_EN.
module mlp_host_sequencer #(
  parameter int W_BYTES_PER_COL = 2,
  parameter int ACT_WORDS       = 2,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        wf_push_col0,
  output logic        wf_push_col1,
  output logic [7:0]  wf_data_in,
  output logic        wf_reset,
  output logic        init_act_valid,
  output logic [15:0] init_act_data,
  output logic        start_mlp,
  output logic        weights_ready,
  input  logic        layer_complete,
  input  logic [31:0] acc0,
  input  logic [31:0] acc1,
  output logic        busy,
  output logic        err_sticky
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_W_BYTES = 4'd1;
  localparam logic [3:0] S_A_LO    = 4'd2;
  localparam logic [3:0] S_A_HI    = 4'd3;
  localparam logic [3:0] S_START   = 4'd4;
  localparam logic [3:0] S_WAIT    = 4'd5;
  localparam logic [3:0] S_TX_RES  = 4'd6;
  localparam logic [3:0] S_TX_STAT = 4'd7;
  localparam logic [3:0] S_TX_ERR  = 4'd8;

  localparam int WN  = 2 * W_BYTES_PER_COL;
  localparam int WCW = $clog2(WN + 1);
  localparam int ACW = $clog2(ACT_WORDS + 1);

  logic [3:0]     state;
  logic [WCW-1:0] wcnt;
  logic [ACW-1:0] acnt;
  logic [7:0]     lo_byte;
  logic [2:0]     tx_idx;
  logic [63:0]    res;
  logic           lc_prev;
  logic           rx_fire;
  logic           tx_fire;
  logic           lc_rise;
  logic           wd_hit;

  // rx_ready is gated by reset so every output reads 0 while reset is held
  assign rx_ready = !reset && (state == S_IDLE || state == S_W_BYTES ||
                               state == S_A_LO || state == S_A_HI);
  assign tx_valid = (state == S_TX_RES || state == S_TX_STAT ||
                     state == S_TX_ERR);
  assign busy     = (state != S_IDLE);
  assign rx_fire  = rx_valid && rx_ready;
  assign tx_fire  = tx_valid && tx_ready;
  assign lc_rise  = layer_complete && !lc_prev;

`ifdef MLP_HOST_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TCW-1:0] wd_cnt;

  assign wd_hit = (wd_cnt + TCW'(1)) == TCW'(TIMEOUT_CYCLES);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      wd_cnt <= '0;
    else if (state != S_WAIT)
      wd_cnt <= '0;
    else
      wd_cnt <= wd_cnt + TCW'(1);
  end
`else
  assign wd_hit = 1'b0;
`endif

  always_comb begin
    tx_data = 8'h00;
    unique case (1'b1)
      state == S_TX_RES:  tx_data = res[{tx_idx, 3'b000} +: 8];
      state == S_TX_STAT: tx_data = {5'b0, err_sticky, weights_ready, 1'b0};
      state == S_TX_ERR:  tx_data = 8'hEE;
      default:            tx_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      wcnt           <= '0;
      acnt           <= '0;
      lo_byte        <= '0;
      tx_idx         <= '0;
      res            <= '0;
      lc_prev        <= 1'b0;
      wf_push_col0   <= 1'b0;
      wf_push_col1   <= 1'b0;
      wf_data_in     <= '0;
      wf_reset       <= 1'b0;
      init_act_valid <= 1'b0;
      init_act_data  <= '0;
      start_mlp      <= 1'b0;
      weights_ready  <= 1'b0;
      err_sticky     <= 1'b0;
    end else begin
      wf_push_col0   <= 1'b0;
      wf_push_col1   <= 1'b0;
      wf_reset       <= 1'b0;
      init_act_valid <= 1'b0;
      start_mlp      <= 1'b0;
      lc_prev        <= layer_complete;
      unique case (state)
        S_IDLE: if (rx_fire) begin
          unique case (rx_data)
            8'h01: begin state <= S_W_BYTES; wcnt <= '0; end
            8'h02: begin state <= S_A_LO; acnt <= '0; end
            8'h03: begin state <= S_START; start_mlp <= 1'b1; end
            8'h04: state <= S_TX_STAT;
            8'h05: begin
              wf_reset      <= 1'b1;
              weights_ready <= 1'b0;
              err_sticky    <= 1'b0;
            end
            default: begin err_sticky <= 1'b1; state <= S_TX_ERR; end
          endcase
        end
        S_W_BYTES: if (rx_fire) begin
          wf_data_in <= rx_data;
          if (wcnt < WCW'(W_BYTES_PER_COL))
            wf_push_col0 <= 1'b1;
          else
            wf_push_col1 <= 1'b1;
          if (wcnt == WCW'(WN - 1)) begin
            weights_ready <= 1'b1;
            state         <= S_IDLE;
          end else begin
            wcnt <= wcnt + WCW'(1);
          end
        end
        S_A_LO: if (rx_fire) begin
          lo_byte <= rx_data;
          state   <= S_A_HI;
        end
        S_A_HI: if (rx_fire) begin
          init_act_valid <= 1'b1;
          init_act_data  <= {rx_data, lo_byte};
          if (acnt == ACW'(ACT_WORDS - 1)) begin
            state <= S_IDLE;
          end else begin
            acnt  <= acnt + ACW'(1);
            state <= S_A_LO;
          end
        end
        S_START: begin
          weights_ready <= 1'b0;
          state         <= S_WAIT;
        end
        // a completion edge beats a watchdog expiry in the same cycle
        S_WAIT: begin
          if (lc_rise) begin
            res    <= {acc1, acc0};
            tx_idx <= '0;
            state  <= S_TX_RES;
          end else if (wd_hit) begin
            err_sticky <= 1'b1;
            state      <= S_TX_ERR;
          end
        end
        S_TX_RES: if (tx_fire) begin
          if (tx_idx == 3'd7)
            state <= S_IDLE;
          else
            tx_idx <= tx_idx + 3'd1;
        end
        S_TX_STAT, S_TX_ERR: if (tx_fire) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
